ex_mem_reg: RTL and testbench

- EX/MEM pipeline register directly downstream of the ALU. It captures ALUResult, store data, destination register and MEM/WB control bits.
- It resolves conditional branches from the ALU compare output. Equal and BNE produce 1/0 in bit 0.
- On a taken branch it drives a registered PC redirect and a flush request to the front end.
- It keeps saturating branch/taken counters for debug.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/sat_counter.sv | 30 +++
 rtl/ex_mem_reg.sv | 124 ++++++++++++
 tb/tb_ex_mem_reg.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the EX/MEM boundary.
// Control bundle layout, the no-op control value and default widths.
package pipe_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int PC_WIDTH_DEF   = 9;

    typedef struct packed {
        logic RegWrite;
        logic MemRead;
        logic MemWrite;
        logic MemtoReg;
        logic Branch;
    } ex_mem_ctrl_t;

    localparam ex_mem_ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
// Ports: clk, reset (async active-low), en (count this cycle), count.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en && (count_q != {WIDTH{1'b1}}))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with branch resolution and front-end redirect.
// Inputs: EX slot bundle, mem_stall, hz_flush. Outputs: MEM bundle,
// pc_redirect/br_target/flush_front, saturating branch/taken counters.
module ex_mem_reg
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int PC_WIDTH       = PC_WIDTH_DEF,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ex_valid,
    input  logic [DATA_WIDTH-1:0]     ALUResult,
    input  logic [DATA_WIDTH-1:0]     ex_rs2_data,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  ex_mem_ctrl_t              ex_ctrl,
    input  logic [PC_WIDTH-1:0]       ex_pc,
    input  logic [PC_WIDTH-1:0]       ex_imm,
    input  logic                      mem_stall,
    input  logic                      hz_flush,
    output logic                      mem_valid,
    output logic [DATA_WIDTH-1:0]     mem_alu_result,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [REG_ADDR_WIDTH-1:0] mem_rd,
    output ex_mem_ctrl_t              mem_ctrl,
    output logic                      pc_redirect,
    output logic [PC_WIDTH-1:0]       br_target,
    output logic                      flush_front,
    output logic [CNT_WIDTH-1:0]      branch_cnt,
    output logic [CNT_WIDTH-1:0]      taken_cnt
);

    logic                      valid_q,  valid_d;
    logic [DATA_WIDTH-1:0]     alu_q,    alu_d;
    logic [DATA_WIDTH-1:0]     wdata_q,  wdata_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q,     rd_d;
    ex_mem_ctrl_t              ctrl_q,   ctrl_d;
    logic                      redir_q,  redir_d;
    logic [PC_WIDTH-1:0]       target_q, target_d;

    logic do_load;
    logic is_branch;
    logic taken;

    // A pending redirect means the EX slot is wrong-path, so it bubbles.
    assign do_load   = !mem_stall && !hz_flush && !redir_q;
    assign is_branch = ex_valid && ex_ctrl.Branch;
    assign taken     = is_branch && ALUResult[0];

    always_comb begin
        valid_d  = valid_q;
        alu_d    = alu_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        ctrl_d   = ctrl_q;
        redir_d  = redir_q;
        target_d = target_q;
        if (mem_stall) begin
            // hold everything
        end else if (!do_load) begin
            valid_d = 1'b0;
            alu_d   = '0;
            wdata_d = '0;
            rd_d    = '0;
            ctrl_d  = CTRL_NOP;
            redir_d = 1'b0;
        end else begin
            valid_d = ex_valid;
            alu_d   = ALUResult;
            wdata_d = ex_rs2_data;
            rd_d    = ex_rd;
            ctrl_d  = ex_valid ? ex_ctrl : CTRL_NOP;
            redir_d = taken;
            if (taken)
                target_d = ex_pc + ex_imm;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q  <= 1'b0;
            alu_q    <= '0;
            wdata_q  <= '0;
            rd_q     <= '0;
            ctrl_q   <= CTRL_NOP;
            redir_q  <= 1'b0;
            target_q <= '0;
        end else begin
            valid_q  <= valid_d;
            alu_q    <= alu_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            ctrl_q   <= ctrl_d;
            redir_q  <= redir_d;
            target_q <= target_d;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_branch_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (do_load && is_branch),
        .count (branch_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_taken_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (do_load && taken),
        .count (taken_cnt)
    );

    assign mem_valid      = valid_q;
    assign mem_alu_result = alu_q;
    assign mem_wdata      = wdata_q;
    assign mem_rd         = rd_q;
    assign mem_ctrl       = ctrl_q;
    assign pc_redirect    = redir_q;
    assign br_target      = target_q;
    assign flush_front    = redir_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: per-cycle model compare plus
// directed literal checks. Counters use a narrow width to reach saturation.
module tb_ex_mem_reg;
    import pipe_pkg::*;

    localparam int DW  = 32;
    localparam int PW  = 9;
    localparam int RW  = 5;
    localparam int CW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ex_valid = 1'b0;
    logic [DW-1:0] ALUResult = '0;
    logic [DW-1:0] ex_rs2_data = '0;
    logic [RW-1:0] ex_rd = '0;
    ex_mem_ctrl_t  ex_ctrl = CTRL_NOP;
    logic [PW-1:0] ex_pc = '0;
    logic [PW-1:0] ex_imm = '0;
    logic          mem_stall = 1'b0;
    logic          hz_flush = 1'b0;

    logic          mem_valid;
    logic [DW-1:0] mem_alu_result;
    logic [DW-1:0] mem_wdata;
    logic [RW-1:0] mem_rd;
    ex_mem_ctrl_t  mem_ctrl;
    logic          pc_redirect;
    logic [PW-1:0] br_target;
    logic          flush_front;
    logic [CW-1:0] branch_cnt;
    logic [CW-1:0] taken_cnt;

    int n_chk = 0;
    int n_fail = 0;

    ex_mem_reg #(
        .DATA_WIDTH(DW), .PC_WIDTH(PW),
        .REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid),
        .ALUResult(ALUResult), .ex_rs2_data(ex_rs2_data),
        .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc),
        .ex_imm(ex_imm), .mem_stall(mem_stall),
        .hz_flush(hz_flush), .mem_valid(mem_valid),
        .mem_alu_result(mem_alu_result), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_ctrl(mem_ctrl),
        .pc_redirect(pc_redirect), .br_target(br_target),
        .flush_front(flush_front), .branch_cnt(branch_cnt),
        .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: what MEM must hold, derived from the instruction stream.
    bit            m_valid;
    logic [DW-1:0] m_alu, m_wdata;
    logic [RW-1:0] m_rd;
    logic [4:0]    m_ctrl;
    bit            m_redir;
    logic [PW-1:0] m_tgt;
    int            m_br, m_tk;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid = 0; m_alu = 0; m_wdata = 0; m_rd = 0;
            m_ctrl = 0; m_redir = 0; m_tgt = 0; m_br = 0; m_tk = 0;
        end else if (mem_stall) begin
            // frozen
        end else if (hz_flush || m_redir) begin
            m_valid = 0; m_alu = 0; m_wdata = 0; m_rd = 0;
            m_ctrl = 0; m_redir = 0;
        end else begin
            bit br, tk;
            br = ex_valid && ex_ctrl.Branch;
            tk = br && ALUResult[0];
            m_valid = ex_valid;
            m_alu   = ALUResult;
            m_wdata = ex_rs2_data;
            m_rd    = ex_rd;
            m_ctrl  = ex_valid ? ex_ctrl : 5'd0;
            m_redir = tk;
            if (tk) m_tgt = PW'(int'(ex_pc) + int'(ex_imm));
            if (br) m_br = (m_br + 1 > CMAX) ? CMAX : m_br + 1;
            if (tk) m_tk = (m_tk + 1 > CMAX) ? CMAX : m_tk + 1;
        end
    end

    always @(negedge clk) begin
        #2;
        chk("m.valid", 64'(mem_valid), 64'(m_valid));
        chk("m.alu", 64'(mem_alu_result), 64'(m_alu));
        chk("m.wdata", 64'(mem_wdata), 64'(m_wdata));
        chk("m.rd", 64'(mem_rd), 64'(m_rd));
        chk("m.ctrl", 64'(mem_ctrl), 64'(m_ctrl));
        chk("m.redir", 64'(pc_redirect), 64'(m_redir));
        chk("m.flush", 64'(flush_front), 64'(m_redir));
        chk("m.tgt", 64'(br_target), 64'(m_tgt));
        chk("m.brcnt", 64'(branch_cnt), 64'(m_br));
        chk("m.tkcnt", 64'(taken_cnt), 64'(m_tk));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] alu,
                         input logic [RW-1:0] rd, input logic [4:0] c,
                         input logic [PW-1:0] pc, input logic [PW-1:0] imm);
        ex_valid = v; ALUResult = alu; ex_rd = rd; ex_ctrl = c;
        ex_pc = pc; ex_imm = imm; ex_rs2_data = alu ^ 32'h5A5A_0000;
    endtask

    localparam logic [4:0] C_RW = 5'b10000;
    localparam logic [4:0] C_BR = 5'b00001;

    initial begin
        // reset held with live EX inputs
        drive(1, 32'hDEAD_BEEF, 5'd3, C_RW, 9'h0, 9'h0);
        repeat (3) tick();
        chk("rst.valid", 64'(mem_valid), 64'd0);
        chk("rst.alu", 64'(mem_alu_result), 64'd0);
        chk("rst.redir", 64'(pc_redirect), 64'd0);
        reset = 1'b1;
        tick();
        chk("rel.alu", 64'(mem_alu_result), 64'hDEAD_BEEF);
        chk("rel.valid", 64'(mem_valid), 64'd1);

        // plain load
        drive(1, 32'h10, 5'd5, C_RW, 9'h0, 9'h0);
        tick();
        chk("ld.rd", 64'(mem_rd), 64'd5);
        chk("ld.regwr", 64'(mem_ctrl.RegWrite), 64'd1);
        chk("ld.redir", 64'(pc_redirect), 64'd0);
        chk("ld.brcnt", 64'(branch_cnt), 64'd0);

        // taken branch
        drive(1, 32'h1, 5'd0, C_BR, 9'h040, 9'h1F8);
        tick();
        chk("tk.redir", 64'(pc_redirect), 64'd1);
        chk("tk.tgt", 64'(br_target), 64'h038);
        chk("tk.flush", 64'(flush_front), 64'd1);
        chk("tk.tkcnt", 64'(taken_cnt), 64'd1);
        drive(1, 32'h77, 5'd7, C_RW, 9'h0, 9'h0);
        tick();
        chk("sq.valid", 64'(mem_valid), 64'd0);
        chk("sq.redir", 64'(pc_redirect), 64'd0);
        chk("sq.tgt", 64'(br_target), 64'h038);

        // not-taken branch
        drive(1, 32'h0, 5'd0, C_BR, 9'h080, 9'h010);
        tick();
        chk("nt.redir", 64'(pc_redirect), 64'd0);
        chk("nt.brcnt", 64'(branch_cnt), 64'd2);
        chk("nt.tkcnt", 64'(taken_cnt), 64'd1);

        // invalid slot with control bits set never writes
        drive(0, 32'h55, 5'd9, C_RW | 5'b00100, 9'h0, 9'h0);
        tick();
        chk("inv.ctrl", 64'(mem_ctrl), 64'd0);
        chk("inv.valid", 64'(mem_valid), 64'd0);

        // external flush alone
        drive(1, 32'h66, 5'd6, C_RW, 9'h0, 9'h0);
        hz_flush = 1'b1;
        tick();
        hz_flush = 1'b0;
        chk("hz.valid", 64'(mem_valid), 64'd0);
        chk("hz.rd", 64'(mem_rd), 64'd0);

        // stall priority over flush and self-squash
        drive(1, 32'h1, 5'd0, C_BR, 9'h100, 9'h010);
        tick();
        chk("st.redir0", 64'(pc_redirect), 64'd1);
        drive(1, 32'h1, 5'd0, C_BR, 9'h000, 9'h020);
        mem_stall = 1'b1;
        hz_flush = 1'b1;
        repeat (2) begin
            tick();
            chk("st.redir", 64'(pc_redirect), 64'd1);
            chk("st.tgt", 64'(br_target), 64'h110);
            chk("st.valid", 64'(mem_valid), 64'd1);
            chk("st.tkcnt", 64'(taken_cnt), 64'd2);
            chk("st.brcnt", 64'(branch_cnt), 64'd3);
        end
        mem_stall = 1'b0;
        hz_flush = 1'b0;
        drive(1, 32'h99, 5'd4, C_RW, 9'h0, 9'h0);
        tick();
        chk("st.bub", 64'(mem_valid), 64'd0);
        chk("st.redir2", 64'(pc_redirect), 64'd0);

        // reset during a stalled redirect
        drive(1, 32'h1, 5'd0, C_BR, 9'h010, 9'h004);
        tick();
        chk("rr.redir0", 64'(pc_redirect), 64'd1);
        mem_stall = 1'b1;
        reset = 1'b0;
        #1;
        chk("rr.redir", 64'(pc_redirect), 64'd0);
        chk("rr.tgt", 64'(br_target), 64'd0);
        chk("rr.tkcnt", 64'(taken_cnt), 64'd0);
        tick();
        mem_stall = 1'b0;
        reset = 1'b1;

        // saturation: continuous taken branches, every other one loads
        drive(1, 32'h1, 5'd0, C_BR, 9'h1F0, 9'h020);
        repeat (2 * ((1 << CW) + 3)) tick();
        chk("sat.brcnt", 64'(branch_cnt), 64'(CMAX));
        chk("sat.tkcnt", 64'(taken_cnt), 64'(CMAX));
        chk("sat.tgt", 64'(br_target), 64'h010);
        drive(0, 32'h0, 5'd0, 5'd0, 9'h0, 9'h0);
        repeat (3) tick();

        #4;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
